uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver: the receive-side counterpart to the existing `uart` transmitter, using the same frame format (1 start bit low, DATA_BITS data bits LSB first, 1 stop bit high, no parity).
Samples the asynchronous `rx_wire` line at mid-bit using a baud counter derived from SYS_CLK.
Presents each received word on a parallel output with a valid/read handshake.
Sits between the board RX pin and the consuming logic (command parser or loopback against `uart`).

Parameters:
DATA_BITS, 8, number of data bits per frame
BAUD, 9600, line rate in bits/s
SYS_CLK, 12000000, clk frequency in Hz; CLKS_PER_BIT = SYS_CLK/BAUD (integer division, 1250 at defaults)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  receiver enable; low aborts any frame and holds FSM in IDLE
rx_wire  input  1  serial line, idle high, asynchronous to clk
rx_read  input  1  consumer acknowledge; clears `valid` and `overrun`
rx_output  output  DATA_BITS  last correctly received word
valid  output  1  `rx_output` holds unread data
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: a word completed while `valid` was already high
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): rx_output=0, valid=0, framing_error=0, overrun=0, busy=0, FSM=IDLE.
  - Synchronizer flops reset to 1 (idle line).
  - Baud counter reset to 0; bit index reset to 0.
- Input sync: `rx_wire` passes through 2 flops (`rx_s`). All decisions use `rx_s`, adding 2 clk of latency.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when enable=1 and a falling edge is seen on `rx_s` (previous 1, current 0): go to START, clear counter.
    - A line that is held low does not retrigger; it must return high first.
  - START: count to CLKS_PER_BIT/2-1.
    - If `rx_s`=0 at that point: go to DATA, clear counter.
    - Otherwise it is a false start: back to IDLE. No flags are raised.
  - DATA: count to CLKS_PER_BIT-1, then sample `rx_s` into shift register position bit_idx (LSB first).
    - After DATA_BITS samples, go to STOP; otherwise increment bit_idx.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - Sample 1: load rx_output, set valid. Go to IDLE.
    - Sample 0: pulse framing_error for exactly 1 clk. rx_output and valid are unchanged and the word is discarded. Go to IDLE.
- busy=1 in START, DATA and STOP.
- Handshake:
  - `valid` stays high until a cycle with rx_read=1; it is cleared on the following edge.
  - rx_read while valid=0 has no effect.
- Overrun:
  - A good stop while valid=1 and rx_read=0: rx_output is overwritten with the new word, valid stays 1, overrun is set.
  - overrun is cleared only by rx_read.
- Simultaneous rx_read and good stop in the same cycle: the new word loads, valid stays 1, overrun is not set (and any prior overrun is cleared).
- enable=0: FSM is forced to IDLE next edge and a partial frame is discarded. rx_output, valid and overrun hold their values; rx_read still works.
- Reset mid-frame: all state returns to reset values immediately; no partial word is ever presented.
- Latency: valid rises about 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT clk after the start edge at `rx_wire`, i.e. about 0.5 bit-time into the stop bit.

Test Plan:
- Reset, rx_wire=1 held for 1 ms with enable=1 -> valid, busy, framing_error, overrun all stay 0; rx_output=0.
- Drive frame 0xA5 (bit period 104167 ns, LSB first, stop=1), then rx_read one cycle later -> valid=1 within the stop bit, rx_output=8'hA5; valid=0 after rx_read.
- Send 0x00 then 0x81 back-to-back without rx_read -> after the 2nd frame rx_output=8'h81, valid=1, overrun=1. A single rx_read clears both.
- Frame 0x3C with stop bit driven 0 -> one-cycle framing_error pulse; rx_output and valid unchanged from the prior state. A following good 0x55 frame is received correctly.
- 20 µs low glitch on rx_wire while idle (less than half a bit) -> false start, busy returns to 0, no valid or error. Also drop enable mid-frame -> busy=0 next clk, no valid.
- Loopback with the `uart` transmitter instance: send 0x00, 0x81 and 0xA5 -> each appears on rx_output with valid. Also assert rst_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
// Mid-bit sampling of a 2-flop synchronised line, valid/read handshake with sticky overrun.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int BAUD      = 9600,
  parameter int SYS_CLK   = 12000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rx_wire,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_output,
  output logic                 valid,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2 - 1;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [1:0]           sync_r;
  logic                 rx_s, rx_prev_r, fall_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]     bit_idx_r, bit_idx_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 good_stop_s, bad_stop_s;

  assign rx_s   = sync_r[1];
  assign fall_s = rx_prev_r & ~rx_s;

  // Synchroniser and edge-detect history; idle line is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[0], rx_wire};
      rx_prev_r <= rx_s;
    end
  end

  // FSM, baud counter, bit index and shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Next-state logic and stop-bit decision
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r + CNT_W'(1);
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    good_stop_s   = 1'b0;
    bad_stop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s     = '0;
        bit_idx_nxt_s = '0;
        if (enable && fall_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_W'(HALF_BIT)) begin
          cnt_nxt_s   = '0;
          state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nxt_s              = '0;
          shift_nxt_s[bit_idx_r] = rx_s;
          if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_nxt_s = '0;
            state_nxt_s   = ST_STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
          good_stop_s = rx_s;
          bad_stop_s  = ~rx_s;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
    // Disable overrides everything and throws away a partial frame
    if (!enable) begin
      state_nxt_s   = ST_IDLE;
      cnt_nxt_s     = '0;
      bit_idx_nxt_s = '0;
      good_stop_s   = 1'b0;
      bad_stop_s    = 1'b0;
    end else begin
      bit_idx_nxt_s = bit_idx_nxt_s;
    end
  end

  // Registered outputs and handshake; a read coinciding with a load clears overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_output     <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      framing_error <= bad_stop_s;
      busy          <= (state_nxt_s != ST_IDLE);
      if (good_stop_s) begin
        rx_output <= shift_r;
        valid     <= 1'b1;
        overrun   <= rx_read ? 1'b0 : (overrun | valid);
      end else if (rx_read) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard queue of expected words, monitor pops on each load.
module tb_uart_rx;

  localparam int CPB = 16;  // 12 MHz / 750 kbaud keeps frames short

  logic       clk = 1'b0;
  logic       rst_n, enable, rx_wire, rx_read;
  logic [7:0] rx_output;
  logic       valid, framing_error, overrun, busy;

  int compared   = 0;
  int mismatched = 0;
  int fe_count   = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.DATA_BITS(8), .BAUD(750000), .SYS_CLK(12000000)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_wire(rx_wire), .rx_read(rx_read),
    .rx_output(rx_output), .valid(valid), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a word is presented when valid rises or the word changes under valid
  logic       valid_q = 1'b0;
  logic [7:0] out_q   = 8'h00;
  logic       fe_q    = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1 && (valid_q !== 1'b1 || rx_output !== out_q)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'h0, rx_output}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_output", {24'h0, rx_output}, {24'h0, exp_q.pop_front()});
      end
    end
    if (framing_error === 1'b1) begin
      fe_count++;
      chk("fe_pulse_width", {31'h0, fe_q}, 32'h0);
    end
    valid_q = valid;
    out_q   = rx_output;
    fe_q    = framing_error;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_wire = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_wire = d[i];
      wait_clk(CPB);
    end
    rx_wire = stop;
    wait_clk(CPB);
    rx_wire = 1'b1;
    wait_clk(CPB);
  endtask

  task automatic read_pulse();
    rx_read = 1'b1;
    wait_clk(1);
    rx_read = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; rx_wire = 1'b1; rx_read = 1'b0;
    wait_clk(3);
    chk("rst_output", {24'h0, rx_output}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;

    // Idle line must produce nothing
    wait_clk(200);
    chk("idle_valid", {31'h0, valid}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_fe_count", fe_count, 32'd0);
    chk("idle_overrun", {31'h0, overrun}, 32'h0);
    chk("idle_output", {24'h0, rx_output}, 32'h0);

    // Single frame then read
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("a5_valid", {31'h0, valid}, 32'h1);
    chk("a5_overrun", {31'h0, overrun}, 32'h0);
    read_pulse();
    chk("a5_valid_cleared", {31'h0, valid}, 32'h0);

    // Back-to-back without read gives overrun
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    chk("ovr_first_overrun", {31'h0, overrun}, 32'h0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    chk("ovr_valid", {31'h0, valid}, 32'h1);
    chk("ovr_overrun", {31'h0, overrun}, 32'h1);
    chk("ovr_output", {24'h0, rx_output}, 32'h81);
    read_pulse();
    chk("ovr_valid_cleared", {31'h0, valid}, 32'h0);
    chk("ovr_overrun_cleared", {31'h0, overrun}, 32'h0);

    // Bad stop bit: one pulse, word discarded
    send_frame(8'h3C, 1'b0);
    chk("fe_count", fe_count, 32'd1);
    chk("fe_valid", {31'h0, valid}, 32'h0);
    chk("fe_output_held", {24'h0, rx_output}, 32'h81);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    chk("after_fe_valid", {31'h0, valid}, 32'h1);
    read_pulse();

    // Short glitch: START entered then abandoned
    rx_wire = 1'b0;
    wait_clk(3);
    rx_wire = 1'b1;
    wait_clk(1);
    chk("glitch_busy_seen", {31'h0, busy}, 32'h1);
    wait_clk(30);
    chk("glitch_busy_clear", {31'h0, busy}, 32'h0);
    chk("glitch_valid", {31'h0, valid}, 32'h0);
    chk("glitch_fe_count", fe_count, 32'd1);

    // Disable mid-frame
    rx_wire = 1'b0;
    wait_clk(3 * CPB);
    chk("dis_busy_before", {31'h0, busy}, 32'h1);
    enable = 1'b0;
    wait_clk(1);
    chk("dis_busy_after", {31'h0, busy}, 32'h0);
    rx_wire = 1'b1;
    wait_clk(8 * CPB);
    enable = 1'b1;
    wait_clk(2 * CPB);
    chk("dis_valid", {31'h0, valid}, 32'h0);
    chk("dis_busy_idle", {31'h0, busy}, 32'h0);

    // Loopback-style transmissions
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    read_pulse();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    read_pulse();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("lb_valid", {31'h0, valid}, 32'h1);

    // Reset in the middle of the next frame, with A5 still unread
    rx_wire = 1'b0;
    wait_clk(4 * CPB);
    rst_n = 1'b0;
    #1;
    chk("mrst_output", {24'h0, rx_output}, 32'h0);
    chk("mrst_valid", {31'h0, valid}, 32'h0);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_overrun", {31'h0, overrun}, 32'h0);
    chk("mrst_fe", {31'h0, framing_error}, 32'h0);
    wait_clk(2);
    rx_wire = 1'b1;
    rst_n = 1'b1;
    wait_clk(12 * CPB);
    chk("post_rst_valid", {31'h0, valid}, 32'h0);
    chk("post_rst_output", {24'h0, rx_output}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
